// File: rtl/eng_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eng_seq_pkg
// Description : Shared types and constants for the engine sequencer.
//               - eng_seq_state_t : sequencer FSM state encoding
//               - c_TMO_CYC_DEFAULT : default watchdog limit in cycles
//               - is_wait_state() : true while the engine handshake is open
// Revision    : 1.0 - initial release
// ============================================================================
package eng_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_STEP      = 3'd5,
    ST_FINISH    = 3'd6
  } eng_seq_state_t;

  localparam int unsigned c_TMO_CYC_DEFAULT = 1000;

  // The two states in which the sequencer is waiting on the engine; these
  // are the only cycles the watchdog accumulates.
  function automatic logic is_wait_state(input eng_seq_state_t s);
    return (s == ST_WAIT_ACK) || (s == ST_WAIT_DONE);
  endfunction

endpackage : eng_seq_pkg
`default_nettype wire

// File: rtl/eng_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : eng_seq_watchdog
// Description : Cycle counter that flags a hung engine. Counts cycles while
//               'en' is high, restarts from zero on 'clr', and reports
//               'expired' during the TMO_CYC-th counted cycle.
//               Only instantiated when ENG_SEQ_TIMEOUT_EN is defined.
// Ports       : clk     - rising-edge clock
//               rst     - asynchronous active-low reset
//               clr     - synchronous counter clear (priority over en)
//               en      - count enable
//               expired - high while the limit is reached and en is high
// Revision    : 1.0 - initial release
// ============================================================================
module eng_seq_watchdog
  import eng_seq_pkg::*;
#(
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = c_TMO_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Compare against TMO_CYC-1: the counter holds the number of cycles
  // already spent, so the cycle in which it equals TMO_CYC-1 is the
  // TMO_CYC-th waiting cycle.
  localparam logic [TMO_W-1:0] c_LIMIT = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != c_LIMIT)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == c_LIMIT);

endmodule : eng_seq_watchdog
`default_nettype wire

// File: rtl/eng_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eng_seq_ctrl
// Description : Engine sequencer. Runs an external engine iter_cnt times per
//               accepted start edge using the eng_start / eng_done handshake,
//               strobes the iteration counter and reports completion.
//               Optional feature macro: ENG_SEQ_TIMEOUT_EN adds a watchdog
//               that aborts a run (err=1, done pulse) after TMO_CYC cycles of
//               waiting on the engine. Without it err is constant 0.
// Ports       : clk       in   rising-edge clock
//               rst       in   asynchronous active-low reset
//               start     in   level request, 0->1 edge accepted in IDLE
//               iter_cnt  in   number of runs, sampled on accepted start
//               eng_done  in   engine status, 1 = idle/finished
//               eng_start out  one-cycle engine launch pulse
//               rst_count out  one-cycle pulse at sequence begin
//               inc_count out  one-cycle pulse per completed run
//               iter_idx  out  runs completed in current sequence
//               busy      out  high outside IDLE
//               done      out  one-cycle pulse at sequence end
//               err       out  sticky watchdog abort flag
// Revision    : 1.0 - initial release
// ============================================================================
module eng_seq_ctrl
  import eng_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = c_TMO_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] iter_cnt,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             rst_count,
  output logic             inc_count,
  output logic [CNT_W-1:0] iter_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  eng_seq_state_t   state_q;
  eng_seq_state_t   state_d;
  logic             start_q;
  logic [CNT_W-1:0] iter_lat_q;
  logic [CNT_W-1:0] iter_lat_d;
  logic [CNT_W-1:0] iter_idx_q;
  logic [CNT_W-1:0] iter_idx_d;
  logic             eng_start_q;
  logic             eng_start_d;
  logic             err_q;
  logic             err_d;

  logic             w_start_edge;
  logic [CNT_W:0]   w_idx_inc;
  logic             w_last_run;
  logic             w_expired;

  assign w_start_edge = start & ~start_q;

  // One extra bit so the last-run compare cannot alias when iter_lat is
  // the largest representable count.
  assign w_idx_inc  = {1'b0, iter_idx_q} + (CNT_W + 1)'(1);
  assign w_last_run = (w_idx_inc == {1'b0, iter_lat_q});

`ifdef ENG_SEQ_TIMEOUT_EN
  eng_seq_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_LAUNCH),
    .en      (is_wait_state(state_q)),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-register logic
  // --------------------------------------------------------------------------
  // eng_start is registered so no input reaches an output combinationally.
  // It is armed on the edge that enters (or stays in) LAUNCH while eng_done
  // is high, so the pulse is visible during the LAUNCH cycle itself; the FSM
  // leaves LAUNCH on the edge that ends that pulse.
  always_comb begin
    state_d     = state_q;
    iter_lat_d  = iter_lat_q;
    iter_idx_d  = iter_idx_q;
    eng_start_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start_edge) begin
          iter_lat_d = iter_cnt;
          err_d      = 1'b0;
          state_d    = (iter_cnt == '0) ? ST_FINISH : ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        iter_idx_d  = '0;
        state_d     = ST_LAUNCH;
        eng_start_d = eng_done;
      end

      ST_LAUNCH: begin
        if (eng_start_q) begin
          state_d = ST_WAIT_ACK;
        end else begin
          eng_start_d = eng_done;
        end
      end

      ST_WAIT_ACK: begin
        if (w_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (!eng_done) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (w_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (eng_done) begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        iter_idx_d = w_idx_inc[CNT_W-1:0];
        if (w_last_run) begin
          state_d = ST_FINISH;
        end else begin
          state_d     = ST_LAUNCH;
          eng_start_d = eng_done;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // start_q resets high so a start level already present when reset is
  // released does not look like a fresh request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b1;
      iter_lat_q  <= '0;
      iter_idx_q  <= '0;
      eng_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      iter_lat_q  <= iter_lat_d;
      iter_idx_q  <= iter_idx_d;
      eng_start_q <= eng_start_d;
      err_q       <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or pure decodes of the state register
  // --------------------------------------------------------------------------
  assign eng_start = eng_start_q;
  assign rst_count = (state_q == ST_CLEAR);
  assign inc_count = (state_q == ST_STEP);
  assign done      = (state_q == ST_FINISH);
  assign busy      = (state_q != ST_IDLE);
  assign iter_idx  = iter_idx_q;
  assign err       = err_q;

endmodule : eng_seq_ctrl
`default_nettype wire

// File: tb/tb_eng_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eng_seq_ctrl
// Description : Self-checking bench for eng_seq_ctrl. A behavioural engine
//               answers eng_start; each started sequence pushes its expected
//               outcome to a scoreboard which is popped on every done pulse.
//               Watchdog scenario is compiled only with ENG_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eng_seq_ctrl;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned TMO_CYC = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b1;
  logic [CNT_W-1:0] iter_cnt = '0;
  wire              eng_done;
  wire              eng_start;
  wire              rst_count;
  wire              inc_count;
  wire [CNT_W-1:0]  iter_idx;
  wire              busy;
  wire              done;
  wire              err;

  always #5 clk = ~clk;

  eng_seq_ctrl #(
    .CNT_W   (CNT_W),
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .iter_cnt  (iter_cnt),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .rst_count (rst_count),
    .inc_count (inc_count),
    .iter_idx  (iter_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ---------------------------------------------------------------- checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- engine model
  int busy_len  = 5;
  int launches  = 0;
  int stuck_run = 0;
  bit hold_low  = 1'b0;
  bit kick      = 1'b0;
  int eng_rem   = 0;

  always @(posedge clk) begin
    if (kick) begin
      eng_rem <= 0;
    end else if (eng_start) begin
      launches <= launches + 1;
      eng_rem  <= (launches + 1 == stuck_run) ? 1000000 : busy_len;
    end else if (eng_rem > 0) begin
      eng_rem <= eng_rem - 1;
    end
  end

  assign eng_done = (eng_rem == 0) && !hold_low;

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    int idx;
    int err;
    int n_rst;
    int n_launch;
    int n_inc;
    int lat;    // cycles from last eng_start to done; -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  int cyc = 0;
  int m_rst = 0, m_launch = 0, m_inc = 0, last_launch = 0, tot_launch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      m_rst = 0; m_launch = 0; m_inc = 0;
    end else begin
      if (rst_count) m_rst++;
      if (eng_start) begin
        m_launch++; tot_launch++; last_launch = cyc;
      end
      if (inc_count) m_inc++;
      if (done) begin
        check("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("iter_idx", iter_idx, sb_e.idx);
          check("err", err, sb_e.err);
          check("rst_count_n", m_rst, sb_e.n_rst);
          check("eng_start_n", m_launch, sb_e.n_launch);
          check("inc_count_n", m_inc, sb_e.n_inc);
          if (sb_e.lat >= 0) check("done_latency", cyc - last_launch, sb_e.lat);
        end
        m_rst = 0; m_launch = 0; m_inc = 0;
      end
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic push_exp(input int idx, input int e, input int nr, input int nl,
                          input int ni, input int lat);
    exp_t x;
    x.idx = idx; x.err = e; x.n_rst = nr; x.n_launch = nl; x.n_inc = ni; x.lat = lat;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == max_cyc) check("done_timeout", done, 1);
  endtask

  task automatic pulse_start(input int cnt);
    iter_cnt = CNT_W'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  int snap;

  initial begin
    // Reset asserted with start already high.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {eng_start, rst_count, inc_count, busy, done, err, iter_idx}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("held_start_busy", busy, 0);
    check("held_start_rst_count", m_rst, 0);
    start = 1'b0;
    @(negedge clk);
    push_exp(1, 0, 1, 1, 1, busy_len + 3);
    pulse_start(1);
    wait_done(100);

    // Three runs, 5-cycle engine, with start-to-strobe latency.
    repeat (2) @(negedge clk);
    push_exp(3, 0, 1, 3, 3, busy_len + 3);
    iter_cnt = 8'd3;
    start = 1'b1;
    @(negedge clk);
    check("lat_rst_count", rst_count, 1);
    start = 1'b0;
    @(negedge clk);
    check("lat_eng_start", eng_start, 1);
    wait_done(200);
    @(negedge clk);
    check("idle_after_done", {busy, done}, 0);

    // Zero iterations: immediate done, iter_idx untouched.
    push_exp(3, 0, 0, 0, 0, -1);
    snap = tot_launch;
    iter_cnt = 8'd0;
    start = 1'b1;
    @(negedge clk);
    check("zero_done_k1", done, 1);
    start = 1'b0;
    @(negedge clk);
    check("zero_busy_after", busy, 0);
    check("zero_no_launch", tot_launch - snap, 0);

    // Engine busy at launch; extra starts and iter_cnt changes mid-run.
    repeat (2) @(negedge clk);
    busy_len = 4;
    hold_low = 1'b1;
    push_exp(2, 0, 1, 2, 2, busy_len + 3);
    snap = tot_launch;
    pulse_start(2);
    repeat (6) @(negedge clk);
    check("launch_withheld", tot_launch - snap, 0);
    iter_cnt = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold_low = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (4) @(negedge clk);
    check("no_queued_start", busy, 0);

`ifdef ENG_SEQ_TIMEOUT_EN
    // Engine hangs on run 2 of 4.
    busy_len = 3;
    stuck_run = launches + 2;
    push_exp(1, 1, 1, 2, 1, TMO_CYC + 1);
    pulse_start(4);
    wait_done(300);
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1);
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    stuck_run = 0;
    push_exp(1, 0, 1, 1, 1, busy_len + 3);
    iter_cnt = 8'd1;
    start = 1'b1;
    @(negedge clk);
    check("err_cleared", err, 0);
    start = 1'b0;
    wait_done(100);
    repeat (2) @(negedge clk);
`endif

    // Reset while waiting on the engine, then a clean 5-run sequence.
    busy_len = 6;
    push_exp(5, 0, 1, 5, 5, busy_len + 3);
    pulse_start(5);
    snap = 0;
    while (!eng_start && snap < 50) begin
      @(negedge clk);
      snap++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_reset_outputs", {eng_start, rst_count, inc_count, busy, done, err, iter_idx}, 0);
    sb_q.delete();
    kick = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hold_no_done", done, 0);
    rst = 1'b1;
    kick = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(5, 0, 1, 5, 5, busy_len + 3);
    pulse_start(5);
    wait_done(400);
    repeat (2) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_eng_seq_ctrl
`default_nettype wire
